// File: rtl/demux_1x8_4bit_reg.sv
// demux_1x8_4bit_reg
//   Registered 1-to-8 demultiplexer. A write (wr_en while ready) loads din
//   into the output register chosen by sel and is confirmed by a one-cycle
//   wr_ack pulse on the following cycle. A clr_all request starts an
//   eight-cycle sweep that zeroes O0..O7 one per clock, in index order.
//   Writes are refused (ready low) while the sweep runs.
//
// Optional feature:
//   DEMUX_STROBE_EN  adds the strb output, a registered one-hot of the
//                    index written, high only in the wr_ack cycle.
//
// Ports:
//   clk      in   sole clock, rising edge
//   rst      in   asynchronous, active-high reset
//   wr_en    in   write request, qualified by ready
//   sel      in   [2:0] destination index
//   din      in   [WIDTH-1:0] write data
//   clr_all  in   request a zeroing sweep of all eight registers
//   ready    out  write accepted this cycle (combinational)
//   wr_ack   out  one-cycle pulse after each accepted write
//   O0..O7   out  [WIDTH-1:0] registered destination values
//   strb     out  [7:0] per-destination update strobe (DEMUX_STROBE_EN only)

module demux_1x8_4bit_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_all,
  output logic             ready,
  output logic             wr_ack,
  output logic [WIDTH-1:0] O0,
  output logic [WIDTH-1:0] O1,
  output logic [WIDTH-1:0] O2,
  output logic [WIDTH-1:0] O3,
  output logic [WIDTH-1:0] O4,
  output logic [WIDTH-1:0] O5,
  output logic [WIDTH-1:0] O6,
  output logic [WIDTH-1:0] O7
`ifdef DEMUX_STROBE_EN
  ,
  output logic [7:0]       strb
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       cnt;
  logic [2:0]       cnt_nxt;
  logic [WIDTH-1:0] regs [8];
  logic             wr_go;

  // clr_all in IDLE drops ready in the same cycle, which is what gives the
  // clear request priority over a simultaneous write.
  assign ready = (state == IDLE) && !clr_all;
  assign wr_go = wr_en && ready;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (clr_all) begin
          state_nxt = CLEAR;
          cnt_nxt   = 3'd0;
        end
      end
      CLEAR: begin
        // cnt wraps 7 -> 0 on the final sweep edge, ready for the next sweep.
        cnt_nxt = cnt + 3'd1;
        if (cnt == 3'd7) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: the register file is reset explicitly because outputs must read 0
  // during and after reset; it is only eight small words of flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        regs[i] <= '0;
      end
    end else if (state == CLEAR) begin
      regs[cnt] <= '0;
    end else if (wr_go) begin
      regs[sel] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ack <= 1'b0;
    end else begin
      wr_ack <= wr_go;
    end
  end

`ifdef DEMUX_STROBE_EN
  // Registered alongside wr_ack so the strobe lines up with the acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strb <= 8'd0;
    end else if (wr_go) begin
      strb <= 8'd1 << sel;
    end else begin
      strb <= 8'd0;
    end
  end
`endif

  assign O0 = regs[0];
  assign O1 = regs[1];
  assign O2 = regs[2];
  assign O3 = regs[3];
  assign O4 = regs[4];
  assign O5 = regs[5];
  assign O6 = regs[6];
  assign O7 = regs[7];

endmodule

// File: doc/demux_1x8_4bit_reg.md
DEMUX_1X8_4BIT_REG -- requirements
Module: demux_1x8_4bit_reg

Interface
REQ-001 SHALL have parameter: WIDTH, default 4, data width of din and of each output register.
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: wr_en  input  1  write request, qualified by ready.
REQ-005 SHALL have port: sel  input  3  destination register index, 0..7.
REQ-006 SHALL have port: din  input  WIDTH  write data.
REQ-007 SHALL have port: clr_all  input  1  request to zero all eight registers via a sequential sweep.
REQ-008 SHALL have port: ready  output  1  high when a write is accepted this cycle.
REQ-009 SHALL have port: wr_ack  output  1  one-cycle pulse confirming a completed write.
REQ-010 SHALL have ports: O0..O7  output  WIDTH each  registered destination values.
REQ-011 SHALL have port, only when DEMUX_STROBE_EN is defined: strb  output  8  one-hot per-destination update strobe.

Function
REQ-012 SHALL implement an FSM with states IDLE and CLEAR and a 3-bit sweep counter cnt.
REQ-013 SHALL drive ready combinationally as (state==IDLE) && !clr_all.
REQ-014 SHALL, on a rising edge with wr_en && ready, load O[sel] <= din; all other outputs hold.
REQ-015 SHALL assert wr_ack exactly one cycle after each accepted write, for one cycle; back-to-back writes produce back-to-back pulses.
REQ-016 SHALL ignore wr_en when ready is low: no register change, no wr_ack.
REQ-017 SHALL, on a rising edge in IDLE with clr_all high, enter CLEAR with cnt=0.
REQ-018 SHALL, on each rising edge in CLEAR, set O[cnt] <= 0 and increment cnt; cnt==7 edge returns to IDLE with cnt wrapping to 0.
REQ-019 SHALL make CLEAR last exactly 8 cycles, with ready low throughout.
REQ-020 SHALL ignore clr_all and wr_en while in CLEAR.
REQ-021 SHALL give clr_all priority over simultaneous wr_en in IDLE: write dropped, no wr_ack.
REQ-022 SHALL clear the registers in index order, so O0 is zero one edge after CLEAR entry and O7 after eight.
REQ-023 SHALL accept a write on the first IDLE cycle after CLEAR exits, if clr_all is low.
REQ-024 SHALL treat din as WIDTH bits; no extension or truncation.

Reset
REQ-025 SHALL, while rst is high, force O0..O7=0, state=IDLE, cnt=0, wr_ack=0 and strb=0, independent of clk.
REQ-026 SHALL abort a CLEAR sweep or pending wr_ack immediately on rst assertion; registers not yet swept read 0 from reset.
REQ-027 SHALL resume normal operation on the first rising edge after rst deasserts.

Configuration
REQ-028 SHALL, with DEMUX_STROBE_EN defined, register strb as the one-hot of the written index, asserted only in the cycle wr_ack is high, 0 otherwise, including during CLEAR.
REQ-029 SHALL, without DEMUX_STROBE_EN, omit the strb port and its logic; all other behaviour is identical.

Verification
REQ-030 SHALL cover: reset, then write sel=5 din=4'hA -> next cycle O5=A, wr_ack=1, all other outputs 0, strb=8'b0010_0000 if enabled.
REQ-031 SHALL cover: eight consecutive writes, sel=0..7, din=1..8 -> O0..O7=1..8, with wr_ack high for 8 consecutive cycles.
REQ-032 SHALL cover: with O0..O7=F, pulse clr_all one cycle -> ready low for 8 cycles, O0..O7 zeroed one per edge in order, then ready=1.
REQ-033 SHALL cover: clr_all and wr_en (sel=2, din=3) on the same edge -> no wr_ack, O2 never equals 3, CLEAR runs.
REQ-034 SHALL cover: wr_en held during CLEAR -> no wr_ack, outputs follow the sweep only.
REQ-035 SHALL cover: rst asserted at CLEAR cycle 3 -> all outputs 0 immediately; after release, a write sel=7 din=9 gives O7=9 next cycle.
